// File: rtl/sfx_tone_sequencer.sv
// Retriggerable sound-effect sequencer: plays ROM-defined square-wave notes and
// mixes them onto the mic pass-through feeding Audio_Controller.
module sfx_tone_sequencer #(
    parameter logic [31:0]       AMPL       = 32'd10000000,
    parameter int                HALF_W     = 15,
    parameter logic [HALF_W-1:0] HALF_BASE  = HALF_W'(3000),
    parameter logic [23:0]       NOTE_TICKS = 24'd6250000,
    parameter logic [23:0]       GAP_TICKS  = 24'd625000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        sfx_start,
    input  logic [1:0]  sfx_id,
    input  logic        audio_in_available,
    input  logic        audio_out_allowed,
    input  logic [31:0] left_channel_audio_in,
    input  logic [31:0] right_channel_audio_in,
    output logic        read_audio_in,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic        busy,
    output logic        done,
    output logic [1:0]  note_index
);
    localparam int          HP_W      = HALF_W + 4;
    localparam logic [23:0] NOTE_LAST = NOTE_TICKS - 24'd1;
    localparam logic [23:0] GAP_LAST  = GAP_TICKS - 24'd1;
    localparam logic [31:0] AMPL_NEG  = ~AMPL + 32'd1;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t            state;
    logic [1:0]        cur_id;
    logic              snd;
    logic [HP_W-1:0]   half_cnt;
    logic [23:0]       dur_cnt;
    logic [HP_W-1:0]   hp;
    logic [3:0]        next_code;
    logic              last_note;
    logic [31:0]       sample;

    // Code 0 terminates a sequence; id 3 never starts so its row is empty.
    function automatic logic [3:0] rom_code(input logic [1:0] id, input logic [1:0] slot);
        logic [3:0] c;
        c = 4'd0;
        case ({id, slot})
            4'b00_00: c = 4'd4;
            4'b00_01: c = 4'd3;
            4'b00_10: c = 4'd2;
            4'b01_00: c = 4'd6;
            4'b01_01: c = 4'd8;
            4'b01_10: c = 4'd10;
            4'b10_00: c = 4'd8;
            4'b10_01: c = 4'd8;
            4'b10_10: c = 4'd10;
            4'b10_11: c = 4'd12;
            default:  c = 4'd0;
        endcase
        return c;
    endfunction

    assign hp        = {rom_code(cur_id, note_index), HALF_BASE};
    assign next_code = rom_code(cur_id, note_index + 2'd1);
    assign last_note = (note_index == 2'd3) || (next_code == 4'd0);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            cur_id     <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            note_index <= 2'd0;
            snd        <= 1'b0;
            half_cnt   <= '0;
            dur_cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (sfx_start && sfx_id == 2'd3) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (sfx_start) begin
                state      <= PLAY;
                busy       <= 1'b1;
                cur_id     <= sfx_id;
                note_index <= 2'd0;
                half_cnt   <= '0;
                dur_cnt    <= '0;
                snd        <= 1'b0;
            end else begin
                case (state)
                    PLAY: begin
                        if (half_cnt == hp) begin
                            half_cnt <= '0;
                            snd      <= ~snd;
                        end else begin
                            half_cnt <= half_cnt + 1'b1;
                        end
                        if (dur_cnt == NOTE_LAST) begin
                            dur_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            dur_cnt <= dur_cnt + 24'd1;
                        end
                    end
                    GAP: begin
                        if (dur_cnt == GAP_LAST) begin
                            dur_cnt <= '0;
                            if (last_note) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                note_index <= note_index + 2'd1;
                                half_cnt   <= '0;
                                snd        <= 1'b0;
                                state      <= PLAY;
                            end
                        end else begin
                            dur_cnt <= dur_cnt + 24'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Tone is silent outside PLAY, so reset/idle leaves a pure mic pass-through.
    assign sample = (state == PLAY) ? (snd ? AMPL : AMPL_NEG) : 32'd0;

    assign left_channel_audio_out  = left_channel_audio_in + sample;
    assign right_channel_audio_out = right_channel_audio_in + sample;
    assign write_audio_out         = audio_in_available & audio_out_allowed;
    assign read_audio_in           = audio_in_available & audio_out_allowed;
endmodule

// File: tb/tb_sfx_tone_sequencer.sv
// Randomized bench for sfx_tone_sequencer against a timeline model of the effect ROM.
module tb_sfx_tone_sequencer;
    localparam logic [31:0] AMPL = 32'd10000000;
    localparam int NT  = 400;
    localparam int GT  = 30;
    localparam int PER = NT + GT;
    localparam int HB  = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sfx_start = 1'b0;
    logic [1:0]  sfx_id = 2'd0;
    logic        avail = 1'b0;
    logic        allowed = 1'b0;
    logic [31:0] lin = 32'd0;
    logic [31:0] rin = 32'd0;
    logic        rd, wr, busy, done;
    logic [31:0] lout, rout;
    logic [1:0]  ni;

    int errors = 0;
    int checks = 0;
    int rom [4][4] = '{'{4, 3, 2, 0}, '{6, 8, 10, 0}, '{8, 8, 10, 12}, '{0, 0, 0, 0}};

    sfx_tone_sequencer #(
        .AMPL(AMPL), .HALF_W(4), .HALF_BASE(4'd5),
        .NOTE_TICKS(24'd400), .GAP_TICKS(24'd30)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .sfx_start(sfx_start), .sfx_id(sfx_id),
        .audio_in_available(avail), .audio_out_allowed(allowed),
        .left_channel_audio_in(lin), .right_channel_audio_in(rin),
        .read_audio_in(rd), .write_audio_out(wr),
        .left_channel_audio_out(lout), .right_channel_audio_out(rout),
        .busy(busy), .done(done), .note_index(ni)
    );

    always #5 clk = ~clk;

    function automatic int nnotes(input int id);
        int n = 0;
        for (int s = 0; s < 4; s++)
            if (rom[id][s] != 0 && n == s) n++;
        return n;
    endfunction

    // Expected tone at 'off' cycles after the first PLAY cycle: note k occupies
    // NT cycles then GT silent cycles; each half-wave lasts HP+1 cycles, low first.
    function automatic logic [31:0] exp_smp(input int id, input int off);
        int k, w, hp;
        k = off / PER;
        w = off % PER;
        if (off >= nnotes(id) * PER || w >= NT) return 32'd0;
        hp = rom[id][k] * 16 + HB;
        return ((w / (hp + 1)) % 2 == 1) ? AMPL : (32'd0 - AMPL);
    endfunction

    task automatic tick(input bit rnd);
        @(posedge clk);
        #1;
        sfx_start = 1'b0;
        if (rnd) begin
            lin = $urandom; rin = $urandom;
            avail = 1'($urandom); allowed = 1'($urandom);
        end
        #1;
    endtask

    task automatic start(input int id);
        sfx_start = 1'b1;
        sfx_id = 2'(id);
        tick(1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick(0);
        reset = 1'b0;
        lin = 32'h64; avail = 1'b1; allowed = 1'b1;
        tick(0);
        checks++; if (lout !== 32'h64) begin errors++; $display("FAIL reset_pass got=%h exp=%h", lout, 32'h64); end
        checks++; if (wr !== 1'b1 || rd !== 1'b1) begin errors++; $display("FAIL reset_hs got=%b%b exp=11", wr, rd); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || ni !== 2'd0) begin errors++; $display("FAIL reset_state got=%b%b%0d exp=000", busy, done, ni); end
        allowed = 1'b0;
        #1;
        checks++; if (wr !== 1'b0 || rd !== 1'b0) begin errors++; $display("FAIL hs_blocked got=%b%b exp=00", wr, rd); end
    endtask

    task automatic test_score_timing;
        lin = 32'd0; rin = 32'd0;
        sfx_start = 1'b1; sfx_id = 2'd0;
        tick(0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL score_busy got=%b exp=1", busy); end
        checks++; if (lout !== 32'hFF676980) begin errors++; $display("FAIL score_first got=%h exp=ff676980", lout); end
        repeat (69) tick(0);
        checks++; if (lout !== 32'hFF676980) begin errors++; $display("FAIL score_before_flip got=%h exp=ff676980", lout); end
        tick(0);
        checks++; if (lout !== 32'h00989680) begin errors++; $display("FAIL score_flip got=%h exp=00989680", lout); end
        sfx_start = 1'b1; sfx_id = 2'd3;
        tick(0);
    endtask

    task automatic test_full_sequence;
        int ids [6];
        int id, dn_cnt, total;
        ids = '{0, 1, 2, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2))};
        foreach (ids[i]) begin
            id = ids[i];
            total = nnotes(id) * PER;
            dn_cnt = 0;
            start(id);
            for (int off = 0; off <= total + 3; off++) begin
                if (off > 0) tick(1);
                if (done === 1'b1) dn_cnt++;
                checks++; if (lout !== lin + exp_smp(id, off) || rout !== rin + exp_smp(id, off)) begin
                    errors++; $display("FAIL seq_mix id=%0d off=%0d got=%h exp=%h", id, off, lout, lin + exp_smp(id, off)); end
                checks++; if (busy !== (off < total)) begin errors++; $display("FAIL seq_busy id=%0d off=%0d got=%b exp=%b", id, off, busy, off < total); end
                checks++; if (done !== (off == total)) begin errors++; $display("FAIL seq_done id=%0d off=%0d got=%b exp=%b", id, off, done, off == total); end
                checks++; if (wr !== (avail & allowed) || rd !== (avail & allowed)) begin errors++; $display("FAIL seq_hs off=%0d got=%b%b exp=%b", off, wr, rd, avail & allowed); end
                if (off < total) begin
                    checks++; if (ni !== 2'(off / PER)) begin errors++; $display("FAIL seq_note id=%0d off=%0d got=%0d exp=%0d", id, off, ni, off / PER); end
                end
            end
            checks++; if (dn_cnt != 1) begin errors++; $display("FAIL seq_done_count id=%0d got=%0d exp=1", id, dn_cnt); end
        end
    endtask

    task automatic test_retrigger;
        int total, dn_cnt;
        dn_cnt = 0;
        start(1);
        for (int off = 0; off <= PER + 50; off++) begin
            if (off > 0) tick(1);
            if (done === 1'b1) dn_cnt++;
            checks++; if (lout !== lin + exp_smp(1, off)) begin errors++; $display("FAIL retrig_pre off=%0d got=%h exp=%h", off, lout, lin + exp_smp(1, off)); end
        end
        checks++; if (ni !== 2'd1) begin errors++; $display("FAIL retrig_pre_note got=%0d exp=1", ni); end
        total = nnotes(2) * PER;
        start(2);
        for (int off = 0; off <= total + 2; off++) begin
            if (off > 0) tick(1);
            if (done === 1'b1) dn_cnt++;
            checks++; if (lout !== lin + exp_smp(2, off)) begin errors++; $display("FAIL retrig_mix off=%0d got=%h exp=%h", off, lout, lin + exp_smp(2, off)); end
            checks++; if (done !== (off == total)) begin errors++; $display("FAIL retrig_done off=%0d got=%b exp=%b", off, done, off == total); end
            if (off < total) begin
                checks++; if (ni !== 2'(off / PER)) begin errors++; $display("FAIL retrig_note off=%0d got=%0d exp=%0d", off, ni, off / PER); end
            end
        end
        checks++; if (dn_cnt != 1) begin errors++; $display("FAIL retrig_done_count got=%0d exp=1", dn_cnt); end
    endtask

    task automatic test_abort;
        start(int'($urandom_range(0, 2)));
        repeat (20) tick(1);
        sfx_start = 1'b1; sfx_id = 2'd3;
        tick(1);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_state got=%b%b exp=00", busy, done); end
        checks++; if (lout !== lin || rout !== rin) begin errors++; $display("FAIL abort_silence got=%h exp=%h", lout, lin); end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++; if (busy !== 1'b0 || done !== 1'b0 || lout !== lin) begin errors++; $display("FAIL abort_idle i=%0d got=%b%b exp=00", i, busy, done); end
        end
    endtask

    task automatic test_reset_mid;
        start(2);
        repeat (150) tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || ni !== 2'd0) begin errors++; $display("FAIL rstmid_state got=%b%b%0d exp=000", busy, done, ni); end
        checks++; if (lout !== lin || rout !== rin) begin errors++; $display("FAIL rstmid_silence got=%h exp=%h", lout, lin); end
        reset = 1'b1; sfx_start = 1'b1; sfx_id = 2'd0;
        tick(1);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_priority got=%b exp=0", busy); end
        tick(1);
        checks++; if (busy !== 1'b0 || lout !== lin) begin errors++; $display("FAIL rst_priority_after got=%b exp=0", busy); end
    endtask

    task automatic test_wrap;
        lin = 32'd0; rin = 32'd0;
        sfx_start = 1'b1; sfx_id = 2'd0;
        tick(0);
        repeat (70) tick(0);
        lin = 32'h7FFFFFFF; rin = 32'hFFFFFFFF;
        #1;
        checks++; if (lout !== 32'h8098967F) begin errors++; $display("FAIL wrap_left got=%h exp=8098967f", lout); end
        checks++; if (rout !== 32'h0098967F) begin errors++; $display("FAIL wrap_right got=%h exp=0098967f", rout); end
    endtask

    initial begin
        test_reset;
        test_score_timing;
        test_full_sequence;
        test_retrigger;
        test_abort;
        test_reset_mid;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
